// File: rtl/data_mem_sub.sv
// Handshaked byte/half/word data memory for the MEM stage.
// Ports: clk, rst (sync, active-high), req_* request bundle, resp_* response.
module data_mem_sub #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LP_CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_sel_in;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [1:0]    w_size;
    logic          w_uns;
    logic [31:0]   w_wdata;
    logic          w_access;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_err;
    logic [3:0]    w_mask;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_rdata;
    logic [31:0]   w_resp_rdata;

    // With no wait states the access happens on the acceptance edge,
    // so the live request inputs are used instead of the latched copy.
    assign w_sel_in = (r_state == S_IDLE);
    assign w_we     = w_sel_in ? req_we       : r_we;
    assign w_addr   = w_sel_in ? req_addr     : r_addr;
    assign w_size   = w_sel_in ? req_size     : r_size;
    assign w_uns    = w_sel_in ? req_unsigned : r_uns;
    assign w_wdata  = w_sel_in ? req_wdata    : r_wdata;

    assign w_access = !rst &&
        ((r_state == S_IDLE && req_valid && (WAIT_CYCLES == 0)) ||
         (r_state == S_WAIT && r_cnt == 4'd0));

    assign w_idx  = w_addr[AW+1:2];
    assign w_lane = w_addr[1:0];

    always_comb begin
        w_err = 1'b0;
        unique case (w_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = w_addr[0];
            2'b10:   w_err = |w_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if ((w_addr >> (AW + 2)) != 32'd0)
            w_err = 1'b1;
    end

    always_comb begin
        w_mask   = 4'b1111;
        w_wlanes = w_wdata;
        unique case (w_size)
            2'b00: begin
                w_mask   = 4'b0001 << w_lane;
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_mask   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_mask   = 4'b1111;
                w_wlanes = w_wdata;
            end
        endcase
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rdata = w_word;
        unique case (w_size)
            2'b00:   w_rdata = {{24{!w_uns & w_byte[7]}}, w_byte};
            2'b01:   w_rdata = {{16{!w_uns & w_half[15]}}, w_half};
            default: w_rdata = w_word;
        endcase
    end

    assign w_resp_rdata = (w_we || w_err) ? 32'd0 : w_rdata;

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_access && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b])
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_resp_rdata;
                            r_resp_err   <= w_err;
                        end else begin
                            r_cnt   <= LP_CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_rdata;
                        r_resp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_data_mem_sub.sv
// Bench for data_mem_sub: one instance with no wait states, one with three.
// Vector table plus hand sequences; responses checked against a queue.
module tb_data_mem_sub;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld [2];
    logic        rdy [2];
    logic        we  [2];
    logic [31:0] addr[2];
    logic [1:0]  sz  [2];
    logic        uns [2];
    logic [31:0] wd  [2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        er  [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t tab[27];
    int   acc[4];
    int   na;
    int   guard;

    always #5 clk = ~clk;

    data_mem_sub #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(we[0]), .req_addr(addr[0]), .req_size(sz[0]),
        .req_unsigned(uns[0]), .req_wdata(wd[0]),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0])
    );

    data_mem_sub #(.DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(we[1]), .req_addr(addr[1]), .req_size(sz[1]),
        .req_unsigned(uns[1]), .req_wdata(wd[1]),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1])
    );

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push(int d, logic [31:0] r, logic e);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    function automatic int qsz(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpop(int d, output exp_t x);
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
    endtask

    // Every wait in the bench goes through here, so responses are
    // scored in the same process as the stimulus.
    task automatic tick();
        exp_t x;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rv[d] === 1'b1) begin
                n_cmp++;
                if (qsz(d) == 0) begin
                    n_bad++;
                    $display("FAIL resp_unexpected dut%0d: got resp_valid=1 want none",
                             d);
                end else begin
                    qpop(d, x);
                    if (rd[d] !== x.rdata || er[d] !== x.err) begin
                        n_bad++;
                        $display("FAIL resp dut%0d: got rdata=%h err=%b want rdata=%h err=%b",
                                 d, rd[d], er[d], x.rdata, x.err);
                    end
                end
            end
        end
    endtask

    task automatic drive(int d, vec_t v);
        we[d]   = v.we;
        addr[d] = v.addr;
        sz[d]   = v.size;
        uns[d]  = v.uns;
        wd[d]   = v.wdata;
        vld[d]  = 1'b1;
    endtask

    task automatic drain(int d);
        int n;
        n = 0;
        while (qsz(d) != 0 && n < 50) begin
            tick();
            n++;
        end
        if (qsz(d) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout dut%0d: got no response want %0d",
                     d, qsz(d));
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic issue(int d, vec_t v);
        int n;
        drive(d, v);
        n = 0;
        while (!rdy[d] && n < 50) begin
            tick();
            n++;
        end
        if (!rdy[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout dut%0d: got req_ready=0 want 1", d);
            vld[d] = 1'b0;
        end else begin
            push(d, v.rdata, v.err);
            @(posedge clk);
            #1 vld[d] = 1'b0;
            drain(d);
            tick();
        end
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [1:0] s,
                                logic u, logic [31:0] wdv,
                                logic [31:0] r, logic e);
        vec_t v;
        v.we = w; v.addr = a; v.size = s; v.uns = u;
        v.wdata = wdv; v.rdata = r; v.err = e;
        return v;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0;
            sz[d] = 2'b10; uns[d] = 1'b0; wd[d] = 32'd0;
        end

        tab[0]  = mk(1, 32'h00,  2, 0, 32'h0BADF00D, 32'h0, 0);
        tab[1]  = mk(1, 32'h10,  2, 0, 32'hDEADBEEF, 32'h0, 0);
        tab[2]  = mk(0, 32'h10,  2, 0, 32'h0, 32'hDEADBEEF, 0);
        tab[3]  = mk(1, 32'h20,  2, 0, 32'h11223344, 32'h0, 0);
        tab[4]  = mk(1, 32'h21,  0, 0, 32'hFFFFFF80, 32'h0, 0);
        tab[5]  = mk(0, 32'h20,  2, 0, 32'h0, 32'h11228044, 0);
        tab[6]  = mk(0, 32'h21,  0, 0, 32'h0, 32'hFFFFFF80, 0);
        tab[7]  = mk(0, 32'h21,  0, 1, 32'h0, 32'h00000080, 0);
        tab[8]  = mk(1, 32'h22,  1, 0, 32'h1234BEEF, 32'h0, 0);
        tab[9]  = mk(0, 32'h20,  2, 0, 32'h0, 32'hBEEF8044, 0);
        tab[10] = mk(0, 32'h22,  1, 0, 32'h0, 32'hFFFFBEEF, 0);
        tab[11] = mk(0, 32'h22,  1, 1, 32'h0, 32'h0000BEEF, 0);
        tab[12] = mk(0, 32'h23,  1, 0, 32'h0, 32'h0, 1);
        tab[13] = mk(1, 32'h26,  2, 0, 32'hAAAAAAAA, 32'h0, 1);
        tab[14] = mk(1, 32'h22,  2, 0, 32'hAAAAAAAA, 32'h0, 1);
        tab[15] = mk(1, 32'h21,  1, 0, 32'h00005555, 32'h0, 1);
        tab[16] = mk(1, 32'h20,  3, 0, 32'h55555555, 32'h0, 1);
        tab[17] = mk(1, 32'h400, 2, 0, 32'h99999999, 32'h0, 1);
        tab[18] = mk(0, 32'h400, 2, 0, 32'h0, 32'h0, 1);
        tab[19] = mk(0, 32'h20,  3, 0, 32'h0, 32'h0, 1);
        tab[20] = mk(0, 32'h20,  2, 1, 32'h0, 32'hBEEF8044, 0);
        tab[21] = mk(0, 32'h00,  2, 0, 32'h0, 32'h0BADF00D, 0);
        tab[22] = mk(0, 32'h20,  0, 0, 32'h0, 32'h00000044, 0);
        tab[23] = mk(0, 32'h23,  0, 0, 32'h0, 32'hFFFFFFBE, 0);
        tab[24] = mk(0, 32'h20,  1, 0, 32'h0, 32'hFFFF8044, 0);
        tab[25] = mk(0, 32'h20,  1, 1, 32'h0, 32'h00008044, 0);
        tab[26] = mk(0, 32'h23,  0, 1, 32'h0, 32'h000000BE, 0);

        // Reset state.
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(rdy[d]), 32'd0);
            chk("rst_resp_valid", 32'(rv[d]), 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
            chk("rst_err", 32'(er[d]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk("ready_after_rst", 32'(rdy[d]), 32'd1);
        tick();

        // Table-driven functional vectors, no wait states.
        for (int i = 0; i < 27; i++)
            issue(0, tab[i]);

        // Ready drops for exactly one cycle, response one cycle later.
        for (int k = 0; k < 2; k++) begin
            drive(0, (k == 0) ? mk(1, 32'h14, 2, 0, 32'hA5A5_0F0F, 0, 0)
                              : mk(0, 32'h14, 2, 0, 32'h0, 32'hA5A5_0F0F, 0));
            chk("w0_ready_accept", 32'(rdy[0]), 32'd1);
            push(0, (k == 0) ? 32'h0 : 32'hA5A5_0F0F, 1'b0);
            @(posedge clk);
            #1 vld[0] = 1'b0;
            tick();
            chk("w0_ready_a1", 32'(rdy[0]), 32'd0);
            chk("w0_valid_a1", 32'(rv[0]), 32'd1);
            tick();
            chk("w0_ready_a2", 32'(rdy[0]), 32'd1);
            chk("w0_valid_a2", 32'(rv[0]), 32'd0);
        end

        // Preload for the wait-state instance.
        issue(1, mk(1, 32'h30, 2, 0, 32'h00000000, 0, 0));
        issue(1, mk(1, 32'h40, 2, 0, 32'h12345678, 0, 0));
        issue(1, mk(1, 32'h54, 2, 0, 32'h01010101, 0, 0));
        issue(1, mk(0, 32'h41, 0, 0, 32'h0, 32'h00000056, 0));

        // Exact latency with three wait states.
        drive(1, mk(0, 32'h40, 2, 0, 32'h0, 32'h12345678, 0));
        chk("w3_ready_accept", 32'(rdy[1]), 32'd1);
        push(1, 32'h12345678, 1'b0);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("w3_valid_a%0d", k), 32'(rv[1]), 32'(k == 4));
            chk($sformatf("w3_ready_a%0d", k), 32'(rdy[1]), 32'(k == 5));
        end

        // Request held valid: accepted every five cycles.
        drive(1, mk(0, 32'h40, 1, 0, 32'h0, 32'h00005678, 0));
        na = 0;
        guard = 0;
        while (na < 4 && guard < 40) begin
            if (rdy[1]) begin
                push(1, 32'h00005678, 1'b0);
                acc[na] = cyc;
                na++;
                if (na == 4) begin
                    @(posedge clk);
                    #1 vld[1] = 1'b0;
                end
            end
            if (na < 4) tick();
            guard++;
        end
        vld[1] = 1'b0;
        chk("held_accepts", na, 4);
        for (int i = 1; i < 4; i++)
            if (i < na)
                chk("held_gap", acc[i] - acc[i-1], 5);
        drain(1);
        tick();

        // Reset two cycles after acceptance abandons the store.
        drive(1, mk(1, 32'h30, 2, 0, 32'hCAFEF00D, 0, 0));
        chk("abort_ready_accept", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        tick();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_ready_in_rst", 32'(rdy[1]), 32'd0);
            chk("abort_no_valid", 32'(rv[1]), 32'd0);
        end
        rst = 1'b0;
        #1 chk("abort_ready_after", 32'(rdy[1]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_late_valid", 32'(rv[1]), 32'd0);
        end
        issue(1, mk(0, 32'h30, 2, 0, 32'h0, 32'h00000000, 0));

        // Inputs change right after acceptance; latched values win.
        drive(1, mk(1, 32'h50, 2, 0, 32'h77665544, 0, 0));
        chk("hold_ready_accept", 32'(rdy[1]), 32'd1);
        push(1, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        vld[1]  = 1'b0;
        addr[1] = 32'h54;
        wd[1]   = 32'hFFFFFFFF;
        sz[1]   = 2'b00;
        drain(1);
        tick();
        issue(1, mk(0, 32'h50, 2, 0, 32'h0, 32'h77665544, 0));
        issue(1, mk(0, 32'h54, 2, 0, 32'h0, 32'h01010101, 0));

        drive(1, mk(0, 32'h50, 2, 0, 32'h0, 32'h77665544, 0));
        push(1, 32'h77665544, 1'b0);
        @(posedge clk);
        #1;
        vld[1]  = 1'b0;
        addr[1] = 32'h57;
        sz[1]   = 2'b00;
        drain(1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
